// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction fetch path: sequencer state, queue entry
// layout and the ROM window check used for both sequential and redirect PCs.
package fetch_pkg;

  typedef enum logic [1:0] {FS_RUN, FS_HALT, FS_FAULT} fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int INSTR_BYTES = 4;

  // Widened by one bit so a PC near 2^64 cannot wrap into the valid window.
  function automatic logic addr_in_rom(input logic [63:0] addr, input int mem_bytes);
    return ({1'b0, addr} + 65'(INSTR_BYTES - 1)) < 65'(unsigned'(mem_bytes));
  endfunction

endpackage

// File: rtl/fetch_sequencer_queue.sv
// Circular fetch queue between the ROM read and decode. Flush beats push and
// pop; storage resets to zero so the head reads as zero out of reset.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int CW     = $clog2(QDEPTH + 1),
  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [QDEPTH];
  fetch_entry_t  mem_d [QDEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr, rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(QDEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[head_q];

  // A pop frees the slot the same cycle, so a full queue can still accept.
  assign wr = push & ~flush & (~full | pop);
  assign rd = pop & ~flush & ~empty;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (wr) begin
        mem_d[tail_q] = wdata;
        tail_d        = ptr_inc(tail_q);
      end
      if (rd) head_d = ptr_inc(head_q);
      count_d = count_q + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, drives the combinational ROM, queues {pc, instr} for decode,
// and handles redirects, halts and sticky address faults.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          MEM_BYTES = 1024,
  parameter int          QDEPTH    = 2,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_address,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  output logic        fault,
  output logic [63:0] fault_pc
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic          fault_q, fault_d;
  logic [63:0]   fault_pc_q, fault_pc_d;

  fetch_entry_t  q_wdata, q_head;
  logic          q_push, q_pop, q_flush, q_full, q_empty;
  logic [CW-1:0] q_count;
  logic          take_redir, fetch_try, fetch_ok, redir_ok, fault_evt;

  assign imem_address = pc_q;
  assign out_valid    = (q_count != '0);
  assign out_instr    = q_head.instr;
  assign out_pc       = q_head.pc;
  assign fault        = fault_q;
  assign fault_pc     = fault_pc_q;

  assign q_pop      = out_ready & ~q_empty;
  assign take_redir = redirect & (state_q != FS_FAULT);
  assign fetch_try  = (state_q == FS_RUN) & ~redirect & ~halt_req;
  assign fetch_ok   = addr_in_rom(pc_q, MEM_BYTES);
  assign redir_ok   = (redirect_pc[1:0] == 2'b00) & addr_in_rom(redirect_pc, MEM_BYTES);
  assign q_flush    = take_redir;
  assign q_push     = fetch_try & fetch_ok & (~q_full | q_pop);
  assign q_wdata    = '{pc: pc_q, instr: imem_instr};

  always_comb begin
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    fault_evt  = 1'b0;
    if (take_redir) begin
      pc_d = redirect_pc;
      if (!redir_ok) begin
        fault_evt  = 1'b1;
        fault_pc_d = redirect_pc;
      end
    end else if (fetch_try) begin
      if (!fetch_ok) begin
        fault_evt  = 1'b1;
        fault_pc_d = pc_q;
      end else if (q_push) begin
        pc_d = pc_q + 64'(INSTR_BYTES);
      end
    end
    if (fault_evt) fault_d = 1'b1;

    state_d = state_q;
    case (state_q)
      FS_RUN:  if (halt_req)  state_d = FS_HALT;
      FS_HALT: if (!halt_req) state_d = FS_RUN;
      default: state_d = FS_FAULT;
    endcase
    if (fault_evt) state_d = FS_FAULT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FS_RUN;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (q_push),
    .wdata (q_wdata),
    .pop   (q_pop),
    .flush (q_flush),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed + randomized bench for fetch_sequencer against a queue-based
// transaction model of the fetch rules (1024-byte ROM, 2-entry queue).
module tb_fetch_sequencer;

  localparam int MEMB  = 1024;
  localparam int DEPTH = 2;
  localparam int M_RUN = 0, M_HALT = 1, M_FAULT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_address;
  logic [31:0] imem_instr;
  logic        out_valid, out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        halt_req;
  logic        fault;
  logic [63:0] fault_pc;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom [MEMB/4];

  logic [63:0] m_pc, m_fpc;
  logic        m_fault;
  int          m_mode;
  logic [63:0] q_pc [$];
  logic [31:0] q_in [$];

  always #5 clk = ~clk;

  assign imem_instr = rom[imem_address[9:2]];

  fetch_sequencer #(.MEM_BYTES(MEMB), .QDEPTH(DEPTH), .RESET_PC(64'd0)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_address (imem_address),
    .imem_instr   (imem_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt_req     (halt_req),
    .fault        (fault),
    .fault_pc     (fault_pc)
  );

  function automatic bit in_range(input logic [63:0] a);
    return a <= 64'(MEMB - 4);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc    = 64'd0;
    m_fpc   = 64'd0;
    m_fault = 1'b0;
    m_mode  = M_RUN;
    q_pc.delete();
    q_in.delete();
  endtask

  task automatic m_set_fault(input logic [63:0] a);
    m_fault = 1'b1;
    m_fpc   = a;
    m_mode  = M_FAULT;
  endtask

  // One clock edge of the fetch rules, using inputs as they stood at the edge.
  task automatic m_step();
    int prev = m_mode;
    if (q_pc.size() > 0 && out_ready) begin
      void'(q_pc.pop_front());
      void'(q_in.pop_front());
    end
    if (m_mode != M_FAULT && redirect) begin
      q_pc.delete();
      q_in.delete();
      m_pc = redirect_pc;
      if (redirect_pc[1:0] != 2'b00 || !in_range(redirect_pc)) m_set_fault(redirect_pc);
    end else if (m_mode == M_RUN && !halt_req) begin
      if (!in_range(m_pc)) m_set_fault(m_pc);
      else if (q_pc.size() < DEPTH) begin
        q_pc.push_back(m_pc);
        q_in.push_back(rom[m_pc[9:2]]);
        m_pc = m_pc + 64'd4;
      end
    end
    if (m_mode != M_FAULT) begin
      if (prev == M_RUN && halt_req)       m_mode = M_HALT;
      else if (prev == M_HALT && !halt_req) m_mode = M_RUN;
    end
  endtask

  task automatic compare();
    chk("imem_address", imem_address, m_pc);
    chk("out_valid", out_valid, q_pc.size() > 0);
    chk("fault", fault, m_fault);
    chk("fault_pc", fault_pc, m_fpc);
    if (q_pc.size() > 0) begin
      chk("out_pc", out_pc, q_pc[0]);
      chk("out_instr", out_instr, q_in[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) m_step();
    @(negedge clk);
    compare();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_pc"}, out_pc, 64'd0);
    chk({tag, "_instr"}, out_instr, 32'd0);
    chk({tag, "_fault"}, fault, 1'b0);
    chk({tag, "_fault_pc"}, fault_pc, 64'd0);
    chk({tag, "_addr"}, imem_address, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_reset();
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < MEMB/4; i++) rom[i] = $urandom;
    out_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 64'd0;
    halt_req    = 1'b0;
    do_reset();

    // Sequential stream from reset.
    repeat (6) tick();

    // Backpressure: queue fills, pc stops, head held; then drain in order.
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (4) tick();

    // Randomized traffic: ready, halt level toggles, aligned in-range redirects.
    repeat (400) begin
      out_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) halt_req = ~halt_req;
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 64'($urandom_range(0, 127)) << 2;
      tick();
    end
    redirect = 1'b0;
    halt_req = 1'b0;

    // Halt for 3 cycles, then resume at the same pc.
    do_reset();
    repeat (3) tick();
    halt_req = 1'b1;
    repeat (3) tick();
    halt_req = 1'b0;
    repeat (3) tick();

    // Async reset arriving mid-halt, between edges.
    halt_req  = 1'b1;
    out_ready = 1'b0;
    repeat (2) tick();
    #2 reset = 1'b1;
    #1;
    check_reset_values("midhalt");
    m_reset();
    @(negedge clk);
    reset     = 1'b0;
    halt_req  = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();

    // Redirect to 0x40 with a full queue.
    out_ready = 1'b0;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 64'h40;
    tick();
    redirect = 1'b0;
    out_ready = 1'b1;
    chk("redir_flush_valid", out_valid, 1'b0);
    tick();
    chk("redir_target_valid", out_valid, 1'b1);
    chk("redir_target_pc", out_pc, 64'h40);
    repeat (3) tick();

    // Misaligned redirect faults and never fetches.
    redirect    = 1'b1;
    redirect_pc = 64'h42;
    tick();
    redirect = 1'b0;
    chk("misalign_fault", fault, 1'b1);
    chk("misalign_fault_pc", fault_pc, 64'h42);
    repeat (5) tick();
    chk("misalign_no_push", out_valid, 1'b0);

    // Walk off the end of the ROM.
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 64'(MEMB - 16);
    tick();
    redirect = 1'b0;
    repeat (8) tick();
    chk("end_fault", fault, 1'b1);
    chk("end_fault_pc", fault_pc, 64'(MEMB));
    redirect    = 1'b1;
    redirect_pc = 64'd0;
    tick();
    redirect = 1'b0;
    tick();
    chk("fault_sticky", fault, 1'b1);
    chk("fault_redirect_ignored", imem_address, 64'(MEMB));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
